// File: rtl/ms_timer_ctrl.sv
// Sequencing FSM for the MM:SS microwave cook timer: keypad capture, 1 s tick generation,
// start/stop/door handling, magnetron control and completion flag for the BCD counter cascade.
module ms_timer_ctrl #(
    parameter int unsigned TICK_DIV   = 100,
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic        door_closed,
    input  logic        keypad_valid,
    input  logic [15:0] digit_in,
    input  logic        all_zero,
    output logic        load_n,
    output logic        cnt_clear_n,
    output logic        enab,
    output logic [15:0] numero,
    output logic        magnetron_on,
    output logic        done,
    output logic [1:0]  state
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TW = (DONE_TICKS > 0) ? $clog2(DONE_TICKS + 1) : 1;
    localparam logic [PW-1:0] PreMax  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TickMax = TW'(DONE_TICKS);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e        st_q, st_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          start_q;
    logic          load_n_q, load_n_d;
    logic          cnt_clear_n_q, cnt_clear_n_d;
    logic          enab_q, enab_d;
    logic [15:0]   numero_q, numero_d;
    logic          magnetron_q, magnetron_d;
    logic          done_q, done_d;

    logic          start_rise;
    logic          entry_ok;
    logic          presc_wrap;
    logic [PW-1:0] presc_inc;
    logic [TW-1:0] tick_inc;

    assign start_rise = start & ~start_q;
    assign entry_ok   = (digit_in[15:12] <= 4'd9) && (digit_in[11:8] <= 4'd9) &&
                        (digit_in[7:4] <= 4'd5) && (digit_in[3:0] <= 4'd9);
    assign presc_wrap = (presc_q == PreMax);
    assign presc_inc  = presc_wrap ? '0 : presc_q + PW'(1);
    assign tick_inc   = tick_q + TW'(1);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            st_q          <= StIdle;
            presc_q       <= '0;
            tick_q        <= '0;
            start_q       <= 1'b0;
            load_n_q      <= 1'b1;
            cnt_clear_n_q <= 1'b1;
            enab_q        <= 1'b0;
            numero_q      <= '0;
            magnetron_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            st_q          <= st_d;
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            start_q       <= start;
            load_n_q      <= load_n_d;
            cnt_clear_n_q <= cnt_clear_n_d;
            enab_q        <= enab_d;
            numero_q      <= numero_d;
            magnetron_q   <= magnetron_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            StIdle: begin
                if (start_rise && door_closed && !all_zero && !stop) st_d = StRun;
            end
            StRun: begin
                if (all_zero)                  st_d = StDone;
                else if (stop || !door_closed) st_d = StPause;
            end
            StPause: begin
                if (stop)                             st_d = StIdle;
                else if (start_rise && door_closed)   st_d = StRun;
            end
            StDone: begin
                if (stop || !door_closed)                st_d = StIdle;
                else if (presc_wrap && tick_inc == TickMax) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    always_comb begin
        load_n_d      = 1'b1;
        cnt_clear_n_d = 1'b1;
        enab_d        = 1'b0;
        numero_d      = numero_q;
        presc_d       = presc_q;
        tick_d        = tick_q;
        case (st_q)
            StIdle: begin
                if (keypad_valid && entry_ok) begin
                    numero_d = digit_in;
                    load_n_d = 1'b0;
                end
                if (st_d == StRun) presc_d = '0;
            end
            StRun: begin
                if (st_d == StRun) begin
                    presc_d = presc_inc;
                    enab_d  = presc_wrap && !all_zero;
                end else if (st_d == StDone) begin
                    // Restart the prescaler so done spans exactly DONE_TICKS whole ticks.
                    presc_d = '0;
                    tick_d  = '0;
                end
            end
            StPause: begin
                if (st_d == StIdle) begin
                    cnt_clear_n_d = 1'b0;
                    numero_d      = '0;
                end
            end
            StDone: begin
                presc_d = presc_inc;
                if (presc_wrap) tick_d = tick_inc;
            end
            default: ;
        endcase
        magnetron_d = (st_d == StRun);
        done_d      = (st_d == StDone);
    end

    assign load_n       = load_n_q;
    assign cnt_clear_n  = cnt_clear_n_q;
    assign enab         = enab_q;
    assign numero       = numero_q;
    assign magnetron_on = magnetron_q;
    assign done         = done_q;
    assign state        = st_q;

endmodule

// File: tb/tb_ms_timer_ctrl.sv
// Directed bench for ms_timer_ctrl with a behavioural model of the four-digit BCD counter cascade.
module tb_ms_timer_ctrl;

    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StRun   = 2'b01;
    localparam logic [1:0] StPause = 2'b10;
    localparam logic [1:0] StDone  = 2'b11;

    logic        clk;
    logic        clear;
    logic        start;
    logic        stop;
    logic        door_closed;
    logic        keypad_valid;
    logic [15:0] digit_in;
    logic        all_zero;
    logic        load_n;
    logic        cnt_clear_n;
    logic        enab;
    logic [15:0] numero;
    logic        magnetron_on;
    logic        done;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] cnt;

    ms_timer_ctrl #(
        .TICK_DIV  (4),
        .DONE_TICKS(2)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .keypad_valid(keypad_valid),
        .digit_in    (digit_in),
        .all_zero    (all_zero),
        .load_n      (load_n),
        .cnt_clear_n (cnt_clear_n),
        .enab        (enab),
        .numero      (numero),
        .magnetron_on(magnetron_on),
        .done        (done),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = (r[15:12] != 4'd0) ? r[15:12] - 4'd1 : 4'd9;
                end
            end
        end
        return r;
    endfunction

    // Counter cascade: clear beats load beats count.
    always @(posedge clk or negedge clear) begin
        if (!clear)            cnt <= 16'h0000;
        else if (!cnt_clear_n) cnt <= 16'h0000;
        else if (!load_n)      cnt <= numero;
        else if (enab)         cnt <= bcd_dec(cnt);
    end
    assign all_zero = (cnt == 16'h0000);

    task automatic test_reset();
        clear = 1'b0; start = 1'b1; stop = 1'b0; door_closed = 1'b1;
        keypad_valid = 1'b0; digit_in = 16'h0000;
        repeat (2) @(negedge clk);
        if (state !== StIdle) begin $display("FAIL reset_state got %b want %b", state, StIdle); n_bad++; end
        n_cmp++;
        if ({load_n, cnt_clear_n, enab, magnetron_on, done} !== 5'b11000) begin
            $display("FAIL reset_ctrl got %b want 11000", {load_n, cnt_clear_n, enab, magnetron_on, done});
            n_bad++;
        end
        n_cmp++;
        if (numero !== 16'h0000) begin $display("FAIL reset_numero got %h want 0000", numero); n_bad++; end
        n_cmp++;
        clear = 1'b1;
        repeat (3) @(negedge clk);
        if (state !== StIdle) begin $display("FAIL release_state got %b want %b", state, StIdle); n_bad++; end
        n_cmp++;
        if ({load_n, enab, magnetron_on, done} !== 4'b1000) begin
            $display("FAIL release_ctrl got %b want 1000", {load_n, enab, magnetron_on, done});
            n_bad++;
        end
        n_cmp++;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_countdown();
        logic [1:0]  exp_st;
        logic [15:0] exp_cnt;
        logic        exp_en, exp_done;
        keypad_valid = 1'b1; digit_in = 16'h0003;
        @(negedge clk);
        keypad_valid = 1'b0;
        if (load_n !== 1'b0) begin $display("FAIL load_pulse got %b want 0", load_n); n_bad++; end
        n_cmp++;
        if (numero !== 16'h0003) begin $display("FAIL load_numero got %h want 0003", numero); n_bad++; end
        n_cmp++;
        @(negedge clk);
        if (load_n !== 1'b1) begin $display("FAIL load_end got %b want 1", load_n); n_bad++; end
        n_cmp++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (state !== StRun || magnetron_on !== 1'b1) begin
            $display("FAIL run_entry got st=%b mag=%b want st=01 mag=1", state, magnetron_on);
            n_bad++;
        end
        n_cmp++;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            exp_st   = (k <= 13) ? StRun : (k <= 21) ? StDone : StIdle;
            exp_en   = (k == 4) || (k == 8) || (k == 12);
            exp_done = (k >= 14) && (k <= 21);
            exp_cnt  = (k < 5) ? 16'h3 : (k < 9) ? 16'h2 : (k < 13) ? 16'h1 : 16'h0;
            if (state !== exp_st) begin
                $display("FAIL cd_state k=%0d got %b want %b", k, state, exp_st); n_bad++;
            end
            n_cmp++;
            if (enab !== exp_en) begin
                $display("FAIL cd_enab k=%0d got %b want %b", k, enab, exp_en); n_bad++;
            end
            n_cmp++;
            if (done !== exp_done || magnetron_on !== (exp_st == StRun)) begin
                $display("FAIL cd_done_mag k=%0d got done=%b mag=%b want done=%b mag=%b",
                         k, done, magnetron_on, exp_done, (exp_st == StRun));
                n_bad++;
            end
            n_cmp++;
            if (cnt !== exp_cnt) begin
                $display("FAIL cd_cascade k=%0d got %h want %h", k, cnt, exp_cnt); n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_invalid_entry();
        logic [15:0] bad [3];
        bad[0] = 16'h0075; bad[1] = 16'h0A00; bad[2] = 16'h000F;
        for (int i = 0; i < 3; i++) begin
            keypad_valid = 1'b1; digit_in = bad[i];
            @(negedge clk);
            keypad_valid = 1'b0;
            if (load_n !== 1'b1 || numero !== 16'h0003) begin
                $display("FAIL invalid_%h got load_n=%b numero=%h want load_n=1 numero=0003",
                         bad[i], load_n, numero);
                n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_door_pause();
        keypad_valid = 1'b1; digit_in = 16'h0012;
        @(negedge clk);
        keypad_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (state !== StRun) begin $display("FAIL dp_run got %b want 01", state); n_bad++; end
        n_cmp++;
        repeat (2) @(negedge clk);
        door_closed = 1'b0;
        @(negedge clk);
        if (state !== StPause || magnetron_on !== 1'b0 || enab !== 1'b0) begin
            $display("FAIL dp_pause got st=%b mag=%b en=%b want st=10 mag=0 en=0",
                     state, magnetron_on, enab);
            n_bad++;
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (state !== StPause || enab !== 1'b0) begin
                $display("FAIL dp_hold i=%0d got st=%b en=%b want st=10 en=0", i, state, enab);
                n_bad++;
            end
            n_cmp++;
        end
        door_closed = 1'b1;
        @(negedge clk);
        if (state !== StPause) begin $display("FAIL dp_door_shut got %b want 10", state); n_bad++; end
        n_cmp++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (state !== StRun || magnetron_on !== 1'b1) begin
            $display("FAIL dp_resume got st=%b mag=%b want st=01 mag=1", state, magnetron_on);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        if (enab !== 1'b0) begin $display("FAIL dp_enab_early got %b want 0", enab); n_bad++; end
        n_cmp++;
        @(negedge clk);
        if (enab !== 1'b1) begin $display("FAIL dp_enab_resume got %b want 1", enab); n_bad++; end
        n_cmp++;
        @(negedge clk);
        if (cnt !== 16'h0011) begin $display("FAIL dp_cascade got %h want 0011", cnt); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_stop_beats_start();
        stop = 1'b1;
        @(negedge clk);
        if (state !== StPause) begin $display("FAIL sb_pause got %b want 10", state); n_bad++; end
        n_cmp++;
        start = 1'b1;
        @(negedge clk);
        if (state !== StIdle || cnt_clear_n !== 1'b0 || numero !== 16'h0000) begin
            $display("FAIL sb_idle got st=%b clr_n=%b numero=%h want st=00 clr_n=0 numero=0000",
                     state, cnt_clear_n, numero);
            n_bad++;
        end
        n_cmp++;
        stop = 1'b0; start = 1'b0;
        @(negedge clk);
        if (cnt_clear_n !== 1'b1 || cnt !== 16'h0000) begin
            $display("FAIL sb_clear_end got clr_n=%b cnt=%h want clr_n=1 cnt=0000", cnt_clear_n, cnt);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_async_clear();
        keypad_valid = 1'b1; digit_in = 16'h0009;
        @(negedge clk);
        keypad_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        if (state !== StRun || enab !== 1'b1) begin
            $display("FAIL ac_pre got st=%b en=%b want st=01 en=1", state, enab); n_bad++;
        end
        n_cmp++;
        #2 clear = 1'b0;
        #1;
        if (state !== StIdle || magnetron_on !== 1'b0 || enab !== 1'b0 || done !== 1'b0) begin
            $display("FAIL ac_async got st=%b mag=%b en=%b done=%b want 00 0 0 0",
                     state, magnetron_on, enab, done);
            n_bad++;
        end
        n_cmp++;
        if (numero !== 16'h0000 || load_n !== 1'b1) begin
            $display("FAIL ac_outputs got numero=%h load_n=%b want 0000 1", numero, load_n); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        clear = 1'b1;
        repeat (2) @(negedge clk);
        if (state !== StIdle || magnetron_on !== 1'b0) begin
            $display("FAIL ac_after got st=%b mag=%b want 00 0", state, magnetron_on); n_bad++;
        end
        n_cmp++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_countdown();
        test_invalid_entry();
        test_door_pause();
        test_stop_beats_start();
        test_async_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
